// File: rtl/conv_engine_kxk.sv
// rtl/conv_engine_kxk.sv - KxK unsigned convolution engine over a memory-resident image
module conv_engine_kxk #(
    parameter int DATA_W = 8,
    parameter int K      = 2,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 9,
    parameter int ACC_W  = 2*DATA_W+6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pad_en,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] filt_base,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [31:0]       sum_out
);

    localparam int NT = K*K;
    localparam int TW = $clog2(NT+1);
    localparam int KW = $clog2(K+1);
    localparam int RW = $clog2(IMG_H+1);
    localparam int CW = $clog2(IMG_W+1);
    localparam logic [TW-1:0] LAST_TAP = TW'(NT);
    localparam logic [KW-1:0] K_LAST   = KW'(K-1);

    typedef enum logic [2:0] {IDLE, LOAD_FILT, MAC, OUT, FIN} state_t;

    state_t state_q, state_d;

    logic [TW-1:0]     tap_q;
    logic [KW-1:0]     ti_q, tj_q;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic              pad_q;
    logic [ADDR_W-1:0] img_base_q, filt_base_q;
    logic [DATA_W-1:0] coef_q [0:(1<<TW)-1];
    logic [ACC_W-1:0]  acc_q, out_data_q;
    logic              out_last_q;
    logic [31:0]       sum_q;
    logic              pend_pad_q;

    logic [31:0]       pix_r, pix_c, n_rows, n_cols;
    logic              tap_pad, last_col, last_pos;
    logic [TW-1:0]     tap_m1;
    logic [ACC_W-1:0]  prod, acc_next;

    // Tap geometry and the accumulate path for the read issued one cycle earlier
    always_comb begin
        n_rows   = pad_q ? 32'(IMG_H) : 32'(IMG_H-K+1);
        n_cols   = pad_q ? 32'(IMG_W) : 32'(IMG_W-K+1);
        pix_r    = 32'(row_q) + 32'(ti_q);
        pix_c    = 32'(col_q) + 32'(tj_q);
        tap_pad  = pad_q && ((pix_r >= 32'(IMG_H)) || (pix_c >= 32'(IMG_W)));
        last_col = (32'(col_q) == n_cols - 32'd1);
        last_pos = last_col && (32'(row_q) == n_rows - 32'd1);
        tap_m1   = tap_q - TW'(1);
        prod     = pend_pad_q ? '0 : ACC_W'(mem_rdata) * ACC_W'(coef_q[tap_m1]);
        acc_next = acc_q + prod;
    end

    always_comb begin
        state_d  = state_q;
        mem_re   = 1'b0;
        mem_addr = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_FILT;
            end
            LOAD_FILT: begin
                if (tap_q != LAST_TAP) begin
                    mem_re   = 1'b1;
                    mem_addr = ADDR_W'(32'(filt_base_q) + 32'(tap_q));
                end else begin
                    state_d = MAC;
                end
            end
            MAC: begin
                if (tap_q != LAST_TAP) begin
                    // Padded taps still burn their cycle, just without a read
                    if (!tap_pad) begin
                        mem_re   = 1'b1;
                        mem_addr = ADDR_W'(32'(img_base_q) + pix_r * 32'(IMG_W) + pix_c);
                    end
                end else begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_d = out_last_q ? FIN : MAC;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            ti_q        <= '0;
            tj_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            pad_q       <= 1'b0;
            img_base_q  <= '0;
            filt_base_q <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sum_q       <= '0;
            pend_pad_q  <= 1'b0;
            for (int n = 0; n < (1<<TW); n++) coef_q[n] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pad_q       <= pad_en;
                        img_base_q  <= img_base;
                        filt_base_q <= filt_base;
                        sum_q       <= '0;
                        tap_q       <= '0;
                        ti_q        <= '0;
                        tj_q        <= '0;
                        row_q       <= '0;
                        col_q       <= '0;
                        out_last_q  <= 1'b0;
                    end
                end
                LOAD_FILT: begin
                    if (tap_q != '0) coef_q[tap_m1] <= mem_rdata;
                    tap_q <= (tap_q == LAST_TAP) ? '0 : tap_q + TW'(1);
                end
                MAC: begin
                    pend_pad_q <= tap_pad;
                    if (tap_q == '0) acc_q <= '0;
                    else             acc_q <= acc_next;
                    if (tap_q == LAST_TAP) begin
                        out_data_q <= acc_next;
                        out_last_q <= last_pos;
                        tap_q      <= '0;
                        ti_q       <= '0;
                        tj_q       <= '0;
                    end else begin
                        tap_q <= tap_q + TW'(1);
                        if (tj_q == K_LAST) begin
                            tj_q <= '0;
                            ti_q <= ti_q + KW'(1);
                        end else begin
                            tj_q <= tj_q + KW'(1);
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        sum_q <= sum_q + 32'(out_data_q);
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == LOAD_FILT) || (state_q == MAC) || (state_q == OUT);
    assign done      = (state_q == FIN);
    assign sum_out   = sum_q;

endmodule

// File: tb/tb_conv_engine_kxk.sv
// tb/tb_conv_engine_kxk.sv - scoreboard bench for conv_engine_kxk
module tb_conv_engine_kxk;
    localparam int DATA_W = 8;
    localparam int K      = 2;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int ADDR_W = 9;
    localparam int ACC_W  = 2*DATA_W+6;
    localparam int FB     = 0;
    localparam int IB     = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              pad_en = 1'b0;
    logic [ADDR_W-1:0] img_base = ADDR_W'(IB);
    logic [ADDR_W-1:0] filt_base = ADDR_W'(FB);
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [31:0]       sum_out;

    conv_engine_kxk #(
        .DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .ADDR_W(ADDR_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pad_en(pad_en),
        .img_base(img_base), .filt_base(filt_base),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .sum_out(sum_out)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_results = 0;
    int   done_cnt = 0;
    int   bad_addr = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted result
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (mem_re && !((mem_addr >= ADDR_W'(FB) && mem_addr < ADDR_W'(FB+K*K)) ||
                            (mem_addr >= ADDR_W'(IB) && mem_addr < ADDR_W'(IB+IMG_W*IMG_H))))
                bad_addr++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", longint'(out_data), longint'(mon_e.data));
                    check("out_last", longint'(out_last), longint'(mon_e.last));
                end
                n_results++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_uniform(input int fv, input int pv);
        for (int a = 0; a < (1<<ADDR_W); a++) mem[a] = '0;
        for (int a = 0; a < K*K; a++) mem[FB+a] = DATA_W'(fv);
        for (int a = 0; a < IMG_W*IMG_H; a++) mem[IB+a] = DATA_W'(pv);
    endtask

    // Uniform image and filter: each result is unit times the in-bounds tap count
    task automatic push_uniform(input bit pad, input int unit, output int n, output longint s);
        int rows, cols, taps;
        rows = pad ? IMG_H : IMG_H-K+1;
        cols = pad ? IMG_W : IMG_W-K+1;
        n = 0;
        s = 0;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                taps = ((r+1 < IMG_H) ? 2 : 1) * ((c+1 < IMG_W) ? 2 : 1);
                exp_q.push_back('{data: ACC_W'(unit*taps), last: (r == rows-1) && (c == cols-1)});
                n++;
                s += unit*taps;
            end
    endtask

    task automatic run(input string tag, input bit pad, input int exp_n, input longint exp_sum,
                       input bit spurious, input bit stall);
        int  cyc;
        int  w;
        bit  stalled;
        n_results = 0;
        done_cnt  = 0;
        bad_addr  = 0;
        stalled   = 1'b0;
        pad_en    = pad;
        img_base  = ADDR_W'(IB);
        filt_base = ADDR_W'(FB);
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
        pad_en    = ~pad;
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            tick(1);
            cyc++;
            if (cyc == 10) check({tag, "_busy_mid"}, longint'(busy), 1);
            if (spurious && cyc == 40) begin
                start    = 1'b1;
                img_base = ADDR_W'(200);
                tick(1);
                start    = 1'b0;
                img_base = ADDR_W'(IB);
            end
            if (stall && !stalled && n_results == 2) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                w = 0;
                while (!out_valid && w < 50) begin
                    tick(1);
                    w++;
                end
                for (int s = 0; s < 5; s++) begin
                    check("stall_valid", longint'(out_valid), 1);
                    check("stall_data", longint'(out_data), 4);
                    check("stall_mem_re", longint'(mem_re), 0);
                    tick(1);
                end
                out_ready = 1'b1;
            end
        end
        if (done_cnt == 0) check({tag, "_done_timeout"}, 0, 1);
        tick(3);
        check({tag, "_results"}, n_results, exp_n);
        check({tag, "_sum"}, longint'(sum_out), exp_sum);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_bad_addr"}, bad_addr, 0);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_busy_end"}, longint'(busy), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mem_re"}, longint'(mem_re), 0);
        check({tag, "_mem_addr"}, longint'(mem_addr), 0);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_out_last"}, longint'(out_last), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_out_data"}, longint'(out_data), 0);
        check({tag, "_sum_out"}, longint'(sum_out), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int     n;
        longint s;
        int     cyc;

        load_uniform(1, 1);
        tick(3);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        push_uniform(1'b0, 1, n, s);
        check("ones_expected_sum", s, 196);
        run("ones", 1'b0, 49, 196, 1'b0, 1'b0);

        push_uniform(1'b1, 1, n, s);
        check("pad_expected_sum", s, 225);
        run("pad", 1'b1, 64, 225, 1'b0, 1'b0);

        load_uniform(255, 255);
        for (int i = 0; i < 49; i++) exp_q.push_back('{data: ACC_W'(260100), last: (i == 48)});
        run("max", 1'b0, 49, 64'd12744900, 1'b0, 1'b0);

        load_uniform(1, 1);
        push_uniform(1'b0, 1, n, s);
        run("stall", 1'b0, 49, 196, 1'b0, 1'b1);

        push_uniform(1'b0, 1, n, s);
        run("spurious", 1'b0, 49, 196, 1'b1, 1'b0);

        // Filter [1 2; 3 4] over pixel(r,c)=8r+c gives 80r+10c+62
        for (int a = 0; a < K*K; a++) mem[FB+a] = DATA_W'(a+1);
        for (int a = 0; a < IMG_W*IMG_H; a++) mem[IB+a] = DATA_W'(a);
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                exp_q.push_back('{data: ACC_W'(80*r + 10*c + 62), last: (r == 6) && (c == 6)});
        run("pattern", 1'b0, 49, 16268, 1'b0, 1'b0);

        load_uniform(1, 1);
        push_uniform(1'b0, 1, n, s);
        n_results = 0;
        img_base  = ADDR_W'(IB);
        filt_base = ADDR_W'(FB);
        pad_en    = 1'b0;
        start     = 1'b1;
        tick(1);
        start = 1'b0;
        cyc = 0;
        while (n_results < 5 && cyc < 1000) begin
            tick(1);
            cyc++;
        end
        tick(2);
        check("pre_reset_sum", longint'(sum_out), 20);
        check("pre_reset_busy", longint'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrun_reset");
        exp_q.delete();
        tick(3);
        rst_n = 1'b1;
        tick(2);

        push_uniform(1'b0, 1, n, s);
        run("after_reset", 1'b0, 49, 196, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
